// File: rtl/tpsram_fifo_ctrl.sv
// tpsram_fifo_ctrl: width-converting FIFO sequencer around a 512x64-write /
// 4096x8-read two-port SRAM. 64-bit words are written through the SRAM write
// port and streamed out one byte per clock through a small output skid FIFO
// that absorbs the one-cycle SRAM read latency.
module tpsram_fifo_ctrl #(
    parameter int DEPTH_BYTES = 4096,
    parameter int OBUF_DEPTH  = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [63:0] IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [7:0]  OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    input  logic        FLUSH,
    output logic [12:0] LEVEL,
    output logic [63:0] W_DATA,
    output logic [8:0]  W_ADDR,
    output logic        W_EN,
    output logic [11:0] R_ADDR,
    input  logic [7:0]  R_DATA
);

    localparam int IW   = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CNTW = $clog2(OBUF_DEPTH + 1);
    localparam int CW   = CNTW + 1;

    // Occupancy is tracked by r_resv/r_avail, so the pointers only need
    // their address bits; the wrap bits would carry no extra information.
    logic [8:0]      r_wptr;
    logic [11:0]     r_rptr;
    logic [12:0]     r_resv;
    logic [12:0]     r_avail;
    logic            r_inflight;

    logic            r_wen;
    logic [8:0]      r_waddr;
    logic [63:0]     r_wdata;

    logic [7:0]      r_obuf [OBUF_DEPTH];
    logic [IW-1:0]   r_ob_head;
    logic [IW-1:0]   r_ob_tail;
    logic [CNTW-1:0] r_ob_cnt;

    logic            w_accept;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [CW-1:0]   w_occ;
    logic [CW-1:0]   w_lim;

    function automatic logic [IW-1:0] f_next_idx(input logic [IW-1:0] idx);
        if (idx == IW'(OBUF_DEPTH - 1)) begin
            return '0;
        end
        return idx + IW'(1);
    endfunction

    assign IN_READY  = !RESET && !FLUSH && (r_resv <= 13'(DEPTH_BYTES - 8));
    assign w_accept  = IN_VALID && IN_READY;
    assign OUT_VALID = (r_ob_cnt != '0);
    assign OUT_DATA  = r_obuf[r_ob_head];
    assign w_pop     = OUT_VALID && OUT_READY;
    assign w_push    = r_inflight;

    // Issue only if the byte returning next cycle is guaranteed a skid slot,
    // counting the byte already in flight and any byte leaving this cycle.
    assign w_occ   = CW'(r_ob_cnt) + CW'(r_inflight);
    assign w_lim   = CW'(OBUF_DEPTH) + CW'(w_pop);
    assign w_issue = !FLUSH && (r_avail != '0) && (w_occ < w_lim);

    assign R_ADDR = r_rptr;
    assign LEVEL  = r_resv;
    assign W_EN   = r_wen;
    assign W_ADDR = r_waddr;
    assign W_DATA = r_wdata;

    // Write port: register the accepted word one cycle ahead of the SRAM edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_wptr  <= '0;
        end else if (FLUSH) begin
            r_wen  <= 1'b0;
            r_wptr <= '0;
        end else begin
            r_wen <= w_accept;
            if (w_accept) begin
                r_waddr <= r_wptr;
                r_wdata <= IN_DATA;
                r_wptr  <= r_wptr + 9'd1;
            end
        end
    end

    // Byte accounting: reservation (accepted, not popped) and availability
    // (written to SRAM, not yet issued), plus the read pointer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_resv     <= '0;
            r_avail    <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
        end else if (FLUSH) begin
            r_resv     <= '0;
            r_avail    <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_resv     <= r_resv + {9'd0, w_accept, 3'd0} - {12'd0, w_pop};
            r_avail    <= r_avail + {9'd0, r_wen, 3'd0} - {12'd0, w_issue};
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rptr <= r_rptr + 12'd1;
            end
        end
    end

    // Output skid FIFO: captures R_DATA the cycle after issue, head drives OUT_DATA.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                r_obuf[i] <= '0;
            end
            r_ob_head <= '0;
            r_ob_tail <= '0;
            r_ob_cnt  <= '0;
        end else if (FLUSH) begin
            r_ob_head <= '0;
            r_ob_tail <= '0;
            r_ob_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_obuf[r_ob_tail] <= R_DATA;
                r_ob_tail         <= f_next_idx(r_ob_tail);
            end
            if (w_pop) begin
                r_ob_head <= f_next_idx(r_ob_head);
            end
            r_ob_cnt <= r_ob_cnt + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

endmodule

// File: tb/tb_tpsram_fifo_ctrl.sv
// Bench for tpsram_fifo_ctrl: SRAM model, byte-queue reference model with a
// per-cycle compare, and directed scenarios with hand-computed expectations.
module tb_tpsram_fifo_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [63:0] IN_DATA = '0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [7:0]  OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic        FLUSH = 1'b0;
    logic [12:0] LEVEL;
    logic [63:0] W_DATA;
    logic [8:0]  W_ADDR;
    logic        W_EN;
    logic [11:0] R_ADDR;
    logic [7:0]  R_DATA = '0;

    int n_chk  = 0;
    int n_pass = 0;

    tpsram_fifo_ctrl #(.DEPTH_BYTES(4096), .OBUF_DEPTH(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .FLUSH(FLUSH), .LEVEL(LEVEL),
        .W_DATA(W_DATA), .W_ADDR(W_ADDR), .W_EN(W_EN),
        .R_ADDR(R_ADDR), .R_DATA(R_DATA)
    );

    always #5 CLK = ~CLK;

    // SRAM: 512x64 write port, 4096x8 synchronous read port
    logic [7:0] mem [4096];
    always @(posedge CLK) begin
        R_DATA <= mem[R_ADDR];
        if (W_EN) begin
            for (int k = 0; k < 8; k++) begin
                mem[{W_ADDR, 3'(k)}] <= W_DATA[8*k +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: byte queue of accepted-but-unpopped data
    logic [7:0]  q[$];
    bit          exp_wen = 0;
    logic [8:0]  exp_waddr = '0;
    logic [63:0] exp_wdata = '0;
    int unsigned wcount = 0;
    int          popped = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = '0;

    always @(negedge CLK) begin
        if (RESET) begin
            chk("rst_w_en", W_EN, 0);
            chk("rst_w_addr", W_ADDR, 0);
            chk("rst_w_data", W_DATA, 0);
            chk("rst_r_addr", R_ADDR, 0);
            chk("rst_out_valid", OUT_VALID, 0);
            chk("rst_out_data", OUT_DATA, 0);
            chk("rst_level", LEVEL, 0);
            chk("rst_in_ready", IN_READY, 0);
            q.delete();
            exp_wen = 0;
            wcount = 0;
            prev_stall = 0;
        end else begin
            chk("level", LEVEL, q.size());
            chk("in_ready", IN_READY, (!FLUSH && q.size() <= 4088));
            chk("w_en", W_EN, exp_wen);
            if (exp_wen) begin
                chk("w_addr", W_ADDR, exp_waddr);
                chk("w_data", W_DATA, exp_wdata);
            end
            if (OUT_VALID) begin
                chk("out_nonempty", q.size() > 0, 1);
                if (q.size() > 0) chk("out_data", OUT_DATA, q[0]);
            end
            if (prev_stall) begin
                chk("stall_valid", OUT_VALID, 1);
                chk("stall_data", OUT_DATA, prev_data);
            end
            if (FLUSH) begin
                q.delete();
                exp_wen = 0;
                wcount = 0;
            end else begin
                if (OUT_VALID && OUT_READY && q.size() > 0) begin
                    void'(q.pop_front());
                    popped++;
                end
                exp_wen = IN_VALID && IN_READY;
                if (exp_wen) begin
                    exp_waddr = wcount[8:0];
                    exp_wdata = IN_DATA;
                    wcount++;
                    for (int k = 0; k < 8; k++) q.push_back(IN_DATA[8*k +: 8]);
                end
            end
            prev_stall = OUT_VALID && !OUT_READY && !FLUSH;
            prev_data  = OUT_DATA;
        end
    end

    // Present a word until accepted or maxw cycles pass; returns at posedge+1.
    task automatic push_word(input logic [63:0] d, input int maxw, output bit ok);
        IN_DATA = d;
        IN_VALID = 1'b1;
        ok = 0;
        for (int i = 0; i < maxw; i++) begin
            @(negedge CLK);
            if (IN_READY) begin
                ok = 1;
                break;
            end
        end
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
    endtask

    task automatic wait_empty(input string nm, input int bound);
        bit got = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK);
            if (LEVEL == 0 && !OUT_VALID) begin
                got = 1;
                break;
            end
        end
        chk(nm, got, 1);
        @(posedge CLK);
        #1;
    endtask

    // One word into an empty controller with the sink ready: exact latency and byte order.
    task automatic single_word(input logic [63:0] d);
        OUT_READY = 1'b1;
        IN_DATA = d;
        IN_VALID = 1'b1;
        @(negedge CLK);
        chk("sw_in_ready", IN_READY, 1);
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            chk("sw_latency_valid", OUT_VALID, 0);
            if (c == 1) begin
                chk("sw_w_en", W_EN, 1);
                chk("sw_w_data", W_DATA, d);
            end
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            chk("sw_valid", OUT_VALID, 1);
            chk("sw_byte", OUT_DATA, d[8*k +: 8]);
        end
        @(negedge CLK);
        chk("sw_end_valid", OUT_VALID, 0);
        chk("sw_end_level", LEVEL, 0);
        @(posedge CLK);
        #1;
    endtask

    bit prod_done = 0;

    initial begin
        bit ok;
        int n;
        int base;

        // Reset and release
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_hold_ready", IN_READY, 0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("release_ready", IN_READY, 1);
        chk("release_level", LEVEL, 0);
        @(posedge CLK);
        #1;

        // Single word
        single_word(64'h0807060504030201);

        // Fill with sink stalled, then drain at full rate
        OUT_READY = 1'b0;
        for (int i = 0; i < 512; i++) begin
            push_word({32'($urandom), 32'($urandom)}, 20, ok);
            chk("fill_push", ok, 1);
        end
        @(negedge CLK);
        chk("fill_level", LEVEL, 4096);
        chk("fill_ready", IN_READY, 0);
        @(posedge CLK);
        #1;
        push_word(64'hDEADBEEFCAFEF00D, 20, ok);
        chk("fill_513_rejected", ok, 0);
        OUT_READY = 1'b1;
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge CLK);
            if (LEVEL == 0) break;
            n++;
        end
        chk("drain_cycles", n, 4096);
        @(posedge CLK);
        #1;
        wait_empty("drain_done", 20);

        // Wrap and order under random backpressure
        base = popped;
        prod_done = 0;
        fork
            begin
                for (int i = 0; i < 1200; i++) begin
                    push_word({32'($urandom), 16'($urandom), 16'(i)}, 400, ok);
                    chk("wrap_push", ok, 1);
                end
                prod_done = 1;
            end
            begin
                while (!prod_done) begin
                    @(posedge CLK);
                    #1 OUT_READY = 1'($urandom_range(0, 1));
                end
            end
        join
        OUT_READY = 1'b1;
        wait_empty("wrap_drain", 10000);
        chk("wrap_byte_count", popped - base, 9600);

        // Stall stability
        OUT_READY = 1'b0;
        push_word(64'h1716151413121110, 20, ok);
        chk("stall_push_a", ok, 1);
        push_word(64'h1F1E1D1C1B1A1918, 20, ok);
        chk("stall_push_b", ok, 1);
        repeat (6) @(posedge CLK);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("stall_hold_valid", OUT_VALID, 1);
            chk("stall_hold_data", OUT_DATA, 8'h10);
            chk("stall_hold_level", LEVEL, 16);
        end
        @(posedge CLK);
        #1 OUT_READY = 1'b1;
        base = popped;
        wait_empty("stall_drain", 100);
        chk("stall_byte_count", popped - base, 16);

        // Flush with 100 words stored and a read in flight
        OUT_READY = 1'b0;
        for (int i = 0; i < 100; i++) begin
            push_word({32'($urandom), 32'($urandom)}, 20, ok);
            chk("flush_push", ok, 1);
        end
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1 FLUSH = 1'b1;
        @(posedge CLK);
        #1 FLUSH = 1'b0;
        @(negedge CLK);
        chk("flush_valid", OUT_VALID, 0);
        chk("flush_level", LEVEL, 0);
        chk("flush_w_en", W_EN, 0);
        @(posedge CLK);
        #1;
        base = popped;
        single_word(64'hA7A6A5A4A3A2A1A0);
        chk("flush_new_count", popped - base, 8);

        // Asynchronous reset in the middle of a burst
        OUT_READY = 1'b1;
        IN_DATA = 64'h3736353433323130;
        IN_VALID = 1'b1;
        repeat (12) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        chk("arst_w_en", W_EN, 0);
        chk("arst_w_addr", W_ADDR, 0);
        chk("arst_w_data", W_DATA, 0);
        chk("arst_r_addr", R_ADDR, 0);
        chk("arst_out_valid", OUT_VALID, 0);
        chk("arst_out_data", OUT_DATA, 0);
        chk("arst_level", LEVEL, 0);
        chk("arst_in_ready", IN_READY, 0);
        IN_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("arst_release_ready", IN_READY, 1);
        @(posedge CLK);
        #1;
        single_word(64'hC7C6C5C4C3C2C1C0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation exceeded 90000 cycles, %0d/%0d passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
